// File: rtl/grant_pkg.sv
// Shared definitions for the arbiter family: FSM state encoding and index-width helper.
package grant_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Never returns 0, so a single-requester index still has a legal 1-bit width.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_arbiter.sv
// Combinational fixed-priority arbiter: the highest set request index wins, one-hot output.
module priority_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Ascending scan, so the last (highest) set bit overrides lower ones.
  always_comb begin
    grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) grant = WIDTH'(1) << i;
    end
  end

endmodule

// File: rtl/grant_hold_ctrl.sv
// Registered grant holder: latches the arbiter winner in IDLE and keeps it frozen
// until done, owner withdrawal or the MAX_HOLD timeout releases it.
module grant_hold_ctrl
  import grant_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);

  localparam int               CNT_W    = idx_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_grant, w_grant_nxt, w_win;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_win_idx;
  logic             r_valid, w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_owner_req, w_at_limit;

  priority_arbiter #(.WIDTH(WIDTH)) u_arb (
    .req   (req),
    .grant (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_win[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_owner_req = req[r_idx];
  assign w_at_limit  = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win;
          w_idx_nxt   = w_win_idx;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // done and withdrawal outrank the limit, so only a pure timeout pulses.
        if (done || !w_owner_req || w_at_limit) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_idx_nxt     = '0;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = !done && w_owner_req && w_at_limit;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Self-checking bench for grant_hold_ctrl: vector table, directed corner sequences,
// and a randomized run against a duration-based reference model.
module tb_grant_hold_ctrl;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic             done;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic             timeout;

  int n_cmp = 0;
  int n_err = 0;

  grant_hold_ctrl #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: who owns the resource and for how many visible cycles.
  int m_owner = -1;
  int m_held  = 0;
  bit m_to    = 1'b0;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [WIDTH-1:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < WIDTH; i++) if (r[i]) m_owner = i;
      if (m_owner >= 0) m_held = 1;
    end else if (d || !r[m_owner]) begin
      m_owner = -1;
    end else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [WIDTH-1:0] model_grant();
    return (m_owner >= 0) ? WIDTH'(1) << m_owner : '0;
  endfunction

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic [WIDTH-1:0] eg, input logic eto);
    logic [1:0] ei;
    ei = 2'd0;
    for (int i = 0; i < WIDTH; i++) if (eg[i]) ei = 2'(i);
    cmp({nm, ".grant"},       8'(grant),       8'(eg));
    cmp({nm, ".grant_valid"}, 8'(grant_valid), 8'(|eg));
    cmp({nm, ".grant_idx"},   8'(grant_idx),   8'(ei));
    cmp({nm, ".timeout"},     8'(timeout),     8'(eto));
  endtask

  task automatic step(input logic [WIDTH-1:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [WIDTH-1:0] req;
    logic             done;
    logic [WIDTH-1:0] g;
    logic             to;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'b0101, 1'b0, 4'b0100, 1'b0};
    tbl[1]  = '{4'b1101, 1'b0, 4'b0100, 1'b0};
    tbl[2]  = '{4'b1101, 1'b1, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1101, 1'b0, 4'b1000, 1'b0};
    tbl[4]  = '{4'b1101, 1'b1, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0010, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[10] = '{4'b0011, 1'b1, 4'b0000, 1'b0};
    tbl[11] = '{4'b0011, 1'b0, 4'b0010, 1'b0};

    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 4'b0000, 1'b0);
    rst = 1'b0;
    step(4'b1111, 1'b0);
    chk("reset_release", 4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    chk("reset_withdraw", 4'b0000, 1'b0);

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].req, tbl[k].done);
      chk($sformatf("vec%0d", k), tbl[k].g, tbl[k].to);
    end

    // Timeout: exactly MAX_HOLD granted cycles, a pulse, one bubble, re-grant.
    step(4'b0000, 1'b0);
    chk("to_idle", 4'b0000, 1'b0);
    for (int k = 0; k < MAX_HOLD; k++) begin
      step(4'b0010, 1'b0);
      chk($sformatf("to_hold%0d", k), 4'b0010, 1'b0);
    end
    step(4'b0010, 1'b0);
    chk("to_pulse", 4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    chk("to_regrant", 4'b0010, 1'b0);

    // done on the limit cycle wins over the timeout.
    step(4'b0000, 1'b0);
    chk("prec_idle", 4'b0000, 1'b0);
    for (int k = 0; k < MAX_HOLD; k++) step(4'b0010, 1'b0);
    chk("prec_last", 4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    chk("prec_done", 4'b0000, 1'b0);

    // Withdrawal on the limit cycle also releases without a pulse.
    for (int k = 0; k < MAX_HOLD; k++) step(4'b0100, 1'b0);
    chk("wd_last", 4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("wd_release", 4'b0000, 1'b0);

    // Asynchronous reset between edges while BUSY.
    step(4'b0100, 1'b0);
    chk("arst_busy", 4'b0100, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_async", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_held", 4'b0000, 1'b0);
    rst = 1'b0;
    model_reset();
    step(4'b0001, 1'b0);
    chk("arst_resume", 4'b0001, 1'b0);

    begin
      logic [WIDTH-1:0] r;
      r = 4'b0001;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 15) == 0) r = WIDTH'($urandom);
        step(r, $urandom_range(0, 19) == 0);
        chk("rand", model_grant(), m_to);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
